// File: rtl/apb4_req_arbiter_if.sv
// ============================================================================
// Module      : apb4_req_arbiter_if
// Description : Two-requester front side plus bus-wrapper side of the arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface apb4_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic                  req0;
    logic                  req1;
    logic                  write0;
    logic                  write1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [STRB_WIDTH-1:0] strb0;
    logic [STRB_WIDTH-1:0] strb1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  err0;
    logic                  err1;

    // Bus-wrapper side
    logic                  transfer;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slverr;
    logic                  busy;

    modport slave (
        input  req0, req1, write0, write1, addr0, addr1,
               wdata0, wdata1, strb0, strb1,
               ready, rdata, slverr,
        output ack0, ack1, rdata0, rdata1, err0, err1,
               transfer, write, addr, wdata, strb, busy
    );

    modport master (
        output req0, req1, write0, write1, addr0, addr1,
               wdata0, wdata1, strb0, strb1,
               ready, rdata, slverr,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
               transfer, write, addr, wdata, strb, busy
    );
endinterface

`default_nettype wire

// File: rtl/apb4_req_arbiter.sv
// ============================================================================
// Module      : apb4_req_arbiter
// Description : Round-robin arbiter of two requesters onto one APB4 wrapper,
//               with per-transfer wait timeout and post-abort drain.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb4_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    apb4_req_arbiter_if.slave       bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic [7:0]            r_wait_cnt;
    logic                  r_transfer;
    logic                  r_busy;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_err0;
    logic                  r_err1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_elig0;
    logic w_elig1;
    logic w_any;
    logic w_grant1;

    // A requester being acked this cycle is masked so its stale REQ is ignored.
    assign w_elig0  = bus.req0 & ~r_ack0;
    assign w_elig1  = bus.req1 & ~r_ack1;
    assign w_any    = w_elig0 | w_elig1;
    assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_wait_cnt <= '0;
            r_transfer <= 1'b0;
            r_busy     <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_XFER;
                        r_transfer <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= '0;
                        r_last     <= w_grant1;
                        r_write    <= w_grant1 ? bus.write1 : bus.write0;
                        r_addr     <= w_grant1 ? bus.addr1  : bus.addr0;
                        r_wdata    <= w_grant1 ? bus.wdata1 : bus.wdata0;
                        r_strb     <= w_grant1 ? bus.strb1  : bus.strb0;
                    end
                end
                ST_XFER: begin
                    // READY takes priority over the timeout on the same cycle.
                    if (bus.ready) begin
                        r_state    <= ST_IDLE;
                        r_transfer <= 1'b0;
                        r_busy     <= 1'b0;
                        if (r_last) begin
                            r_ack1 <= 1'b1;
                            r_err1 <= bus.slverr;
                            if (!r_write) r_rdata1 <= bus.rdata;
                        end else begin
                            r_ack0 <= 1'b1;
                            r_err0 <= bus.slverr;
                            if (!r_write) r_rdata0 <= bus.rdata;
                        end
                    end else if (r_wait_cnt == c_timeout_last) begin
                        r_state    <= ST_DRAIN;
                        r_transfer <= 1'b0;
                        if (r_last) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= 1'b1;
                            r_rdata1 <= '0;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= 1'b1;
                            r_rdata0 <= '0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // The late completion of an aborted transfer is swallowed.
                    if (bus.ready) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_transfer <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.transfer = r_transfer;
    assign bus.busy     = r_busy;
    assign bus.write    = r_write;
    assign bus.addr     = r_addr;
    assign bus.wdata    = r_wdata;
    assign bus.strb     = r_strb;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.err0     = r_err0;
    assign bus.err1     = r_err1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_apb4_req_arbiter.sv
// ============================================================================
// Module      : tb_apb4_req_arbiter
// Description : Directed self-checking bench with an expected-completion queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_apb4_req_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb4_req_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    apb4_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.req0 = 1'b0;   ifc.req1 = 1'b0;
        ifc.write0 = 1'b0; ifc.write1 = 1'b0;
        ifc.addr0 = '0;    ifc.addr1 = '0;
        ifc.wdata0 = '0;   ifc.wdata1 = '0;
        ifc.strb0 = '0;    ifc.strb1 = '0;
        ifc.ready = 1'b0;  ifc.rdata = '0;  ifc.slverr = 1'b0;
    endtask

    // Step until an ACK appears (bounded) and compare it against the oldest expectation.
    task automatic wait_ack(input int budget, input string tag, output int cycles);
        exp_t e;
        bit   got;
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            step();
            cycles++;
            if (ifc.ack0 || ifc.ack1) got = 1'b1;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (!got) begin
                chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
            end else begin
                chk({tag, "_ack0"}, 32'(ifc.ack0), 32'(e.idx == 0));
                chk({tag, "_ack1"}, 32'(ifc.ack1), 32'(e.idx == 1));
                chk({tag, "_err"}, 32'((e.idx == 0) ? ifc.err0 : ifc.err1), 32'(e.err));
                chk({tag, "_err_other"}, 32'((e.idx == 0) ? ifc.err1 : ifc.err0), 32'd0);
                chk({tag, "_rdata"}, (e.idx == 0) ? ifc.rdata0 : ifc.rdata1, e.rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_transfer", 32'(ifc.transfer), 32'd0);
        chk("rst_busy",     32'(ifc.busy),     32'd0);
        chk("rst_ack0",     32'(ifc.ack0),     32'd0);
        chk("rst_ack1",     32'(ifc.ack1),     32'd0);
        chk("rst_err0",     32'(ifc.err0),     32'd0);
        chk("rst_err1",     32'(ifc.err1),     32'd0);
        chk("rst_rdata0",   ifc.rdata0,        32'd0);
        chk("rst_rdata1",   ifc.rdata1,        32'd0);
        chk("rst_write",    32'(ifc.write),    32'd0);
        chk("rst_addr",     ifc.addr,          32'd0);
        chk("rst_wdata",    ifc.wdata,         32'd0);
        chk("rst_strb",     32'(ifc.strb),     32'd0);
        rst_n = 1'b1;
        step();

        // Single read, READY on the third XFER cycle
        ifc.req0 = 1'b1; ifc.write0 = 1'b0; ifc.addr0 = 32'h04;
        sb.push_back('{0, 1'b0, 32'hCAFE0001});
        step();
        chk("t1_transfer_c1", 32'(ifc.transfer), 32'd1);
        chk("t1_addr",        ifc.addr,          32'h04);
        chk("t1_write",       32'(ifc.write),    32'd0);
        chk("t1_busy",        32'(ifc.busy),     32'd1);
        ifc.req0 = 1'b0;
        step();
        chk("t1_transfer_c2", 32'(ifc.transfer), 32'd1);
        step();
        chk("t1_transfer_c3", 32'(ifc.transfer), 32'd1);
        ifc.ready = 1'b1; ifc.rdata = 32'hCAFE0001;
        wait_ack(4, "t1", cyc);
        chk("t1_ack_latency",  32'(cyc),          32'd1);
        chk("t1_transfer_end", 32'(ifc.transfer), 32'd0);
        chk("t1_busy_end",     32'(ifc.busy),     32'd0);
        ifc.ready = 1'b0; ifc.rdata = '0;
        step();
        chk("t1_ack_pulse", 32'(ifc.ack0), 32'd0);
        chk("t1_err_clear", 32'(ifc.err0), 32'd0);
        chk("t1_rdata_hold", ifc.rdata0,   32'hCAFE0001);

        // Write from requester 1 with slave error
        ifc.req1 = 1'b1; ifc.write1 = 1'b1; ifc.addr1 = 32'h40;
        ifc.wdata1 = 32'h12345678; ifc.strb1 = 4'hF;
        ifc.ready = 1'b1; ifc.slverr = 1'b1; ifc.rdata = 32'hDEADBEEF;
        sb.push_back('{1, 1'b1, 32'd0});
        step();
        chk("t3_write", 32'(ifc.write), 32'd1);
        chk("t3_addr",  ifc.addr,       32'h40);
        chk("t3_wdata", ifc.wdata,      32'h12345678);
        chk("t3_strb",  32'(ifc.strb),  32'hF);
        ifc.req1 = 1'b0; ifc.write1 = 1'b0; ifc.addr1 = '0; ifc.wdata1 = '0; ifc.strb1 = '0;
        wait_ack(2, "t3", cyc);
        chk("t3_addr_stable",  ifc.addr,  32'h40);
        chk("t3_wdata_stable", ifc.wdata, 32'h12345678);
        ifc.ready = 1'b0; ifc.slverr = 1'b0; ifc.rdata = '0;
        step();
        chk("t3_err_clear", 32'(ifc.err1), 32'd0);

        // Tie with both requests held: expect 0,1,0,1 with one IDLE cycle per ACK
        ifc.req0 = 1'b1; ifc.req1 = 1'b1; ifc.ready = 1'b1;
        ifc.rdata = 32'h10000000;
        for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 1'b0, 32'h10000000 + 32'(k)});
        for (int k = 0; k < 4; k++) begin
            wait_ack(4, $sformatf("tie%0d", k), cyc);
            chk($sformatf("tie%0d_spacing", k), 32'(cyc), 32'd2);
            chk($sformatf("tie%0d_idle", k), 32'(ifc.busy), 32'd0);
            ifc.rdata = 32'h10000000 + 32'(k + 1);
        end
        ifc.req0 = 1'b0; ifc.req1 = 1'b0; ifc.ready = 1'b0; ifc.rdata = '0;

        // Timeout abort then drain
        ifc.req0 = 1'b1; ifc.addr0 = 32'h08;
        sb.push_back('{0, 1'b1, 32'd0});
        step();
        chk("t4_transfer", 32'(ifc.transfer), 32'd1);
        ifc.req0 = 1'b0;
        wait_ack(40, "t4", cyc);
        chk("t4_cycles",       32'(cyc),          32'(TO));
        chk("t4_drain_busy",   32'(ifc.busy),     32'd1);
        chk("t4_drain_notran", 32'(ifc.transfer), 32'd0);
        step();
        chk("t4_drain_hold", 32'(ifc.busy), 32'd1);
        chk("t4_drain_noack", 32'(ifc.ack0), 32'd0);
        ifc.ready = 1'b1; ifc.rdata = 32'hFFFF; ifc.slverr = 1'b1;
        step();
        chk("t4_idle_busy", 32'(ifc.busy), 32'd0);
        chk("t4_late_noack", 32'(ifc.ack0 | ifc.ack1), 32'd0);
        chk("t4_late_noerr", 32'(ifc.err0), 32'd0);
        chk("t4_rdata_zero", ifc.rdata0, 32'd0);
        ifc.ready = 1'b0; ifc.rdata = '0; ifc.slverr = 1'b0;

        // READY on the timeout cycle wins
        ifc.req0 = 1'b1; ifc.addr0 = 32'h0C;
        sb.push_back('{0, 1'b0, 32'hA5});
        step();
        ifc.req0 = 1'b0;
        repeat (TO - 1) step();
        chk("t5_transfer_c16", 32'(ifc.transfer), 32'd1);
        ifc.ready = 1'b1; ifc.rdata = 32'hA5;
        wait_ack(2, "t5", cyc);
        chk("t5_latency", 32'(cyc), 32'd1);
        chk("t5_busy", 32'(ifc.busy), 32'd0);
        ifc.ready = 1'b0; ifc.rdata = '0;
        step();
        chk("t5_no_drain", 32'(ifc.busy), 32'd0);

        // Reset in the middle of XFER
        ifc.req0 = 1'b1; ifc.write0 = 1'b1; ifc.addr0 = 32'h100;
        ifc.wdata0 = 32'h5555AAAA; ifc.strb0 = 4'h3;
        step();
        chk("t6_transfer_c1", 32'(ifc.transfer), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_transfer", 32'(ifc.transfer), 32'd0);
        chk("t6_async_busy",     32'(ifc.busy),     32'd0);
        chk("t6_async_addr",     ifc.addr,          32'd0);
        chk("t6_async_wdata",    ifc.wdata,         32'd0);
        chk("t6_async_strb",     32'(ifc.strb),     32'd0);
        chk("t6_async_write",    32'(ifc.write),    32'd0);
        chk("t6_async_rdata0",   ifc.rdata0,        32'd0);
        ifc.write0 = 1'b0; ifc.req1 = 1'b1; ifc.addr1 = 32'h200;
        step();
        step();
        chk("t6_held_noack", 32'(ifc.ack0 | ifc.ack1), 32'd0);
        rst_n = 1'b1;
        sb.push_back('{0, 1'b0, 32'h77});
        step();
        chk("t6_regrant",    32'(ifc.transfer), 32'd1);
        chk("t6_first_req0", ifc.addr,          32'h100);
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        ifc.ready = 1'b1; ifc.rdata = 32'h77;
        wait_ack(2, "t6", cyc);
        ifc.ready = 1'b0; ifc.rdata = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
